// File: rtl/trace_pkg.sv
// Shared definitions for the writeback debug trace transmitter.
//   TRACE_SYNC    : first byte of every frame, used by the sink to resynchronise.
//   frame_bytes() : frame length in bytes for a given register width.
//   trace_state_t : serialiser states.
//   trace_event_t : one captured writeback event at the default 32-bit width.
//                   The top level declares the same layout at its own XLEN.
package trace_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_event_t;

  // Sync byte + address byte + XLEN/8 data bytes.
  function automatic int frame_bytes(input int xlen);
    return 2 + xlen / 8;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO holding captured trace events.
//   clk, rst : clock and asynchronous active-high reset.
//   push     : write wdata; accepted when not full, or when a pop happens on the same edge.
//   pop      : read the oldest entry into rdata; ignored when empty.
//   wdata    : entry to write.
//   rdata    : registered read data; updated only on a pop and held otherwise.
//   full     : DEPTH entries stored.
//   empty    : no entries stored.
// Pointers carry one extra wrap bit. Equal pointers mean empty. Pointers that
// differ only in the wrap bit mean full.
module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // Storage has no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rdata      <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        rdata      <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/wb_trace_tx.sv
// Writeback debug trace transmitter.
// Captures register-file write events, queues them, and sends each one as a
// frame: A5, {3'b0, addr}, then the data bytes little-endian.
//   clk, rst   : clock and asynchronous active-high reset.
//   in_valid   : writeback event strobe. in_addr and in_data describe the event.
//   out_data   : frame byte.
//   out_valid  : out_data is valid.
//   out_ready  : sink accepts the byte at this edge.
//   overflow   : sticky flag. At least one event was dropped.
//   drop_count : number of dropped events, saturating at 255.
//   empty      : the FIFO is empty and the serialiser is idle.
// The core is never stalled. An event that arrives while the FIFO is full is
// dropped, unless a pop happens on the same edge.
module wb_trace_tx
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [4:0]      in_addr,
  input  logic [XLEN-1:0] in_data,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic [7:0]      drop_count,
  output logic            empty
);

  localparam int NB         = frame_bytes(XLEN);
  localparam int DATA_BYTES = NB - 2;
  localparam int BW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } event_t;

  event_t          wr_event;
  event_t          frame;          // FIFO read register, held for the whole frame
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            drop;

  trace_state_t    state_reg;
  trace_state_t    state_next;
  logic [BW-1:0]   byte_idx_reg;
  logic [BW-1:0]   byte_idx_next;
  logic            last_byte;
  logic [XLEN-1:0] data_shifted;

  logic            overflow_reg;
  logic [7:0]      drop_count_reg;

  assign wr_event = {in_addr, in_data};
  assign push     = in_valid && (!fifo_full || pop);
  assign drop     = in_valid && fifo_full && !pop;

  // The popped entry lands in the FIFO read register. That register serves as
  // the frame register, because it changes only on the next pop, and the next
  // pop happens only when the current frame ends.
  trace_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_event),
    .rdata (frame),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
    end
  end

  assign last_byte = (byte_idx_reg == BW'(DATA_BYTES - 1));

  // Next-state logic. This also decides when the FIFO is popped.
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (out_ready) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (out_ready) begin
          state_next    = DATA;
          byte_idx_next = '0;
        end
      end
      DATA: begin
        if (out_ready) begin
          if (last_byte) begin
            // Pop the next entry on the edge that sends the last byte, so
            // back-to-back frames run without a gap.
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = SYNC;
            end else begin
              state_next = IDLE;
            end
          end else begin
            byte_idx_next = byte_idx_reg + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_shifted = frame.data >> {byte_idx_reg, 3'b000};

  // Output logic. Outputs are decoded from the state only, so they hold
  // steady while the sink stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_reg)
      SYNC: begin
        out_valid = 1'b1;
        out_data  = TRACE_SYNC;
      end
      ADDR: begin
        out_valid = 1'b1;
        out_data  = {3'b000, frame.addr};
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = data_shifted[7:0];
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  // Drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'h00;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign empty      = fifo_empty && (state_reg == IDLE);

endmodule

// File: tb/tb_wb_trace_tx.sv
module tb_wb_trace_tx;

  localparam int DEPTH = 8;
  localparam int NB    = 6;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        empty;

  logic        in_valid64;
  logic [4:0]  in_addr64;
  logic [63:0] in_data64;
  logic [7:0]  out_data64;
  logic        out_valid64;
  logic        out_ready64;
  logic        overflow64;
  logic [7:0]  drop_count64;
  logic        empty64;

  int total = 0;
  int bad   = 0;

  // Reference model: pending events, plus the byte stream of the frame in flight.
  logic [36:0] m_fifo[$];
  logic [7:0]  m_frame[$];
  int          m_drops;
  logic        m_ovf;

  wb_trace_tx #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .drop_count(drop_count), .empty(empty)
  );

  wb_trace_tx #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_addr(in_addr64), .in_data(in_data64),
    .out_data(out_data64), .out_valid(out_valid64), .out_ready(out_ready64),
    .overflow(overflow64), .drop_count(drop_count64), .empty(empty64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame byte k of a 32-bit event {addr, data}.
  function automatic logic [7:0] frame_byte(input logic [36:0] e, input int k);
    logic [31:0] d;
    d = e[31:0] >> (8 * (k - 2));
    if (k == 0) return 8'hA5;
    if (k == 1) return {3'b000, e[36:32]};
    return d[7:0];
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_frame.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endfunction

  // One clock edge of the model. Every decision uses the state from before the edge.
  function automatic void model_edge(input logic v, input logic [4:0] a,
                                     input logic [31:0] d, input logic rdy);
    logic        xfer;
    logic        pop;
    logic        push;
    logic [36:0] e;
    xfer = (m_frame.size() > 0) && rdy;
    pop  = (m_fifo.size() > 0) && ((m_frame.size() == 0) || (xfer && m_frame.size() == 1));
    push = v && ((m_fifo.size() < DEPTH) || pop);
    if (v && !push) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    if (xfer) void'(m_frame.pop_front());
    if (pop) begin
      e = m_fifo.pop_front();
      for (int k = 0; k < NB; k++) m_frame.push_back(frame_byte(e, k));
    end
    if (push) m_fifo.push_back({a, d});
  endfunction

  task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d, input logic rdy);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(v, a, d, rdy);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [36:0] rand_event();
    logic [4:0]  a;
    logic [31:0] d;
    a = 5'($urandom);
    d = $urandom;
    return {a, d};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b0;
    in_valid64 = 1'b0; in_addr64 = '0; in_data64 = '0; out_ready64 = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0)     begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00)     begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (overflow !== 1'b0)      begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (drop_count !== 8'h00)   begin bad++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    total++; if (empty !== 1'b1)         begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (out_valid64 !== 1'b0)   begin bad++; $display("FAIL reset_out_valid64 got=%b exp=0", out_valid64); end
    total++; if (empty64 !== 1'b1)       begin bad++; $display("FAIL reset_empty64 got=%b exp=1", empty64); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("test_reset checked");
  endtask

  task automatic test_single();
    logic [7:0] exp_b[NB];
    exp_b = '{8'hA5, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass out_valid got=%b exp=0", out_valid); end
    total++; if (empty !== 1'b0)     begin bad++; $display("FAIL single_empty_low got=%b exp=0", empty); end
    cycle(1'b0, 5'd0, 32'd0, 1'b1);
    for (int k = 0; k < NB; k++) begin
      if (k > 0) cycle(1'b0, 5'd0, 32'd0, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_b[k]) begin
        bad++; $display("FAIL single_byte%0d got valid=%b data=%h exp valid=1 data=%h", k, out_valid, out_data, exp_b[k]);
      end
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1);
    total++; if (empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL single_done got empty=%b valid=%b exp empty=1 valid=0", empty, out_valid);
    end
    $display("test_single addr=05 data=DEADBEEF checked");
  endtask

  task automatic test_overflow();
    logic [36:0] ev[11];
    logic [7:0]  got[$];
    int          gaps;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ev[i] = rand_event();
      cycle(1'b1, ev[i][36:32], ev[i][31:0], 1'b0);
    end
    // DEPTH entries fit in the FIFO, and one more sits in the frame register.
    total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL overflow_drop_count got=%0d exp=2", drop_count); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
    gaps = 0;
    for (int c = 0; c < 200 && empty !== 1'b1; c++) begin
      if (out_valid === 1'b1) got.push_back(out_data);
      else gaps++;
      cycle(1'b0, 5'd0, 32'd0, 1'b1);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL overflow_drain_timeout empty=%b exp=1", empty); end
    total++; if (gaps != 0)      begin bad++; $display("FAIL overflow_gaps got=%0d exp=0", gaps); end
    total++; if (got.size() != (DEPTH + 1) * NB) begin
      bad++; $display("FAIL overflow_byte_count got=%0d exp=%0d", got.size(), (DEPTH + 1) * NB);
    end
    for (int i = 0; i < DEPTH + 1 && got.size() == (DEPTH + 1) * NB; i++) begin
      for (int k = 0; k < NB; k++) begin
        total++;
        if (got[i*NB+k] !== frame_byte(ev[i], k)) begin
          bad++; $display("FAIL overflow_frame%0d_byte%0d got=%h exp=%h", i, k, got[i*NB+k], frame_byte(ev[i], k));
        end
      end
    end
    $display("test_overflow 11 events, %0d bytes drained", got.size());
  endtask

  task automatic test_backpressure();
    logic [36:0] ev;
    logic        rdy;
    int          k;
    int          hold;
    logic        held;
    do_reset();
    ev = rand_event();
    cycle(1'b1, ev[36:32], ev[31:0], 1'b1);
    k = 0; hold = 0; held = 1'b0;
    for (int c = 0; c < 40 && k < NB; c++) begin
      rdy = 1'b1;
      if (k == 3 && !held) begin held = 1'b1; hold = 4; end
      if (hold > 0) begin
        rdy = 1'b0;
        hold--;
        total++;
        if (out_valid !== 1'b1 || out_data !== frame_byte(ev, 3)) begin
          bad++; $display("FAIL backpressure_hold got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, frame_byte(ev, 3));
        end
      end else if (out_valid === 1'b1) begin
        total++;
        if (out_data !== frame_byte(ev, k)) begin
          bad++; $display("FAIL backpressure_byte%0d got=%h exp=%h", k, out_data, frame_byte(ev, k));
        end
        k++;
      end
      cycle(1'b0, 5'd0, 32'd0, rdy);
    end
    total++; if (k != NB || empty !== 1'b1) begin
      bad++; $display("FAIL backpressure_complete got bytes=%0d empty=%b exp bytes=%0d empty=1", k, empty, NB);
    end
    $display("test_backpressure event=%h checked", ev);
  endtask

  task automatic test_full_same_edge();
    logic [36:0] ev;
    int          c;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      ev = rand_event();
      cycle(1'b1, ev[36:32], ev[31:0], 1'b0);
    end
    c = 0;
    while (m_frame.size() != 1 && c < 20) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1);
      c++;
    end
    ev = rand_event();
    cycle(1'b1, ev[36:32], ev[31:0], 1'b1);
    total++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_same_edge_drop got drops=%0d ovf=%b exp drops=0 ovf=0", drop_count, overflow);
    end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      bad++; $display("FAIL full_same_edge_next got valid=%b data=%h exp valid=1 data=a5", out_valid, out_data);
    end
    for (c = 0; c < 200 && empty !== 1'b1; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== m_frame[0]) begin
        bad++; $display("FAIL full_same_edge_stream got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, m_frame[0]);
      end
      cycle(1'b0, 5'd0, 32'd0, 1'b1);
    end
    total++; if (empty !== 1'b1 || m_frame.size() != 0) begin
      bad++; $display("FAIL full_same_edge_drain empty=%b exp=1", empty);
    end
    $display("test_full_same_edge drained in %0d cycles", c);
  endtask

  task automatic test_async_reset();
    logic [36:0] ev;
    int          k;
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      ev = rand_event();
      cycle(1'b1, ev[36:32], ev[31:0], 1'b0);
    end
    for (int c = 0; c < 10 && m_frame.size() != NB - 4; c++) cycle(1'b0, 5'd0, 32'd0, 1'b1);
    total++; if (out_valid !== 1'b1 || drop_count === 8'd0) begin
      bad++; $display("FAIL async_reset_setup got valid=%b drops=%0d exp valid=1 drops>0", out_valid, drop_count);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00)   begin bad++; $display("FAIL async_reset_data got=%h exp=00", out_data); end
    total++; if (empty !== 1'b1)       begin bad++; $display("FAIL async_reset_empty got=%b exp=1", empty); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL async_reset_overflow got=%b exp=0", overflow); end
    total++; if (drop_count !== 8'h00) begin bad++; $display("FAIL async_reset_drop_count got=%0d exp=0", drop_count); end
    #2 rst = 1'b0;
    model_reset();
    ev = rand_event();
    cycle(1'b1, ev[36:32], ev[31:0], 1'b1);
    k = 0;
    for (int c = 0; c < 20 && k < NB; c++) begin
      if (out_valid === 1'b1) begin
        total++;
        if (out_data !== frame_byte(ev, k)) begin
          bad++; $display("FAIL async_reset_fresh_byte%0d got=%h exp=%h", k, out_data, frame_byte(ev, k));
        end
        k++;
      end
      cycle(1'b0, 5'd0, 32'd0, 1'b1);
    end
    total++; if (k != NB || empty !== 1'b1) begin
      bad++; $display("FAIL async_reset_fresh_complete got bytes=%0d empty=%b exp bytes=%0d empty=1", k, empty, NB);
    end
    $display("test_async_reset fresh event=%h checked", ev);
  endtask

  task automatic test_random();
    logic [36:0] ev;
    logic        v;
    logic        rdy;
    logic        exp_v;
    int          nbad;
    do_reset();
    nbad = bad;
    for (int c = 0; c < 600; c++) begin
      ev  = rand_event();
      v   = ($urandom_range(0, 99) < 40);
      rdy = ($urandom_range(0, 99) < ((c < 300) ? 50 : 85));
      cycle(v, ev[36:32], ev[31:0], rdy);
      exp_v = (m_frame.size() != 0);
      total++; if (out_valid !== exp_v) begin bad++; $display("FAIL random_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
      if (exp_v) begin
        total++; if (out_data !== m_frame[0]) begin bad++; $display("FAIL random_data c=%0d got=%h exp=%h", c, out_data, m_frame[0]); end
      end
      total++; if (empty !== (m_fifo.size() == 0 && !exp_v)) begin
        bad++; $display("FAIL random_empty c=%0d got=%b exp=%b", c, empty, (m_fifo.size() == 0 && !exp_v));
      end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL random_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
      total++; if (drop_count !== 8'(m_drops)) begin bad++; $display("FAIL random_drop_count c=%0d got=%0d exp=%0d", c, drop_count, m_drops); end
    end
    $display("test_random 600 cycles, model drops=%0d, new errors=%0d", m_drops, bad - nbad);
  endtask

  task automatic test_xlen64();
    logic [7:0] exp_b[10];
    int         k;
    exp_b = '{8'hA5, 8'h1F, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    do_reset();
    out_ready64 = 1'b1;
    in_valid64  = 1'b1;
    in_addr64   = 5'd31;
    in_data64   = 64'h0102030405060708;
    cycle(1'b0, 5'd0, 32'd0, 1'b0);
    in_valid64 = 1'b0;
    k = 0;
    for (int c = 0; c < 30 && k < 10; c++) begin
      if (out_valid64 === 1'b1) begin
        total++;
        if (out_data64 !== exp_b[k]) begin
          bad++; $display("FAIL xlen64_byte%0d got=%h exp=%h", k, out_data64, exp_b[k]);
        end
        k++;
      end
      cycle(1'b0, 5'd0, 32'd0, 1'b0);
    end
    total++; if (k != 10 || empty64 !== 1'b1) begin
      bad++; $display("FAIL xlen64_complete got bytes=%0d empty=%b exp bytes=10 empty=1", k, empty64);
    end
    // Fill the FIFO plus the frame register, then drop 254, 1, and 45 more events.
    out_ready64 = 1'b0;
    in_valid64  = 1'b1;
    for (int i = 0; i < DEPTH + 1 + 254; i++) begin
      in_data64 = {$urandom, $urandom};
      cycle(1'b0, 5'd0, 32'd0, 1'b0);
    end
    total++; if (drop_count64 !== 8'd254) begin bad++; $display("FAIL xlen64_drops_254 got=%0d exp=254", drop_count64); end
    cycle(1'b0, 5'd0, 32'd0, 1'b0);
    total++; if (drop_count64 !== 8'd255 || overflow64 !== 1'b1) begin
      bad++; $display("FAIL xlen64_drops_255 got=%0d ovf=%b exp=255 ovf=1", drop_count64, overflow64);
    end
    for (int i = 0; i < 45; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0);
    total++; if (drop_count64 !== 8'd255) begin bad++; $display("FAIL xlen64_saturate got=%0d exp=255", drop_count64); end
    in_valid64 = 1'b0;
    $display("test_xlen64 frame and 300 drops checked, drop_count=%0d", drop_count64);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_full_same_edge();
    test_async_reset();
    test_random();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
